// File: rtl/sim_jtag_seq_driver.sv
`default_nettype none
// ============================================================================
//  Module   : sim_jtag_seq_driver
//  Purpose  : Buffered JTAG sequencer for simulation. A debug-host model
//             pushes multi-bit TMS/TDI shift commands into a small FIFO; the
//             block replays them on the JTAG pins with a programmable TCK
//             half-period, captures TDO on each TCK rising edge and hands the
//             captured vector back through a valid/ready response port. An
//             EXIT command latches a nonzero simulation exit code and halts.
//
//  Ports    : clock, reset             - sole clock, synchronous active-high reset
//             enable, init_done        - pop permission, DUT-ready (made sticky)
//             cmd_valid/ready/op/len/tms/tdi - command push interface
//             resp_valid/ready/data    - captured-TDO response interface
//             jtag_TCK/TMS/TDI/TRSTn   - JTAG pins driven to the DUT
//             jtag_TDO_data/driven     - DUT TDO and its output enable
//             exit                     - 0 while running, exit code otherwise
//
//  Options  : SIM_JTAG_RAND_TDO_EN - when defined, an undriven TDO samples
//             bit 0 of a 16-bit Fibonacci LFSR (seed 16'hACE1) instead of 0.
//
//  Revision : 1.0 - initial release
// ============================================================================
module sim_jtag_seq_driver #(
    parameter int TICK_DELAY = 50,
    parameter int SHIFT_W    = 32,
    parameter int CMD_DEPTH  = 4,
    parameter int LEN_W      = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               init_done,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [SHIFT_W-1:0] cmd_tms,
    input  logic [SHIFT_W-1:0] cmd_tdi,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [SHIFT_W-1:0] resp_data,
    output logic               jtag_TCK,
    output logic               jtag_TMS,
    output logic               jtag_TDI,
    output logic               jtag_TRSTn,
    input  logic               jtag_TDO_data,
    input  logic               jtag_TDO_driven,
    output logic [31:0]        exit
);

    localparam int CNT_W = (TICK_DELAY > 0) ? $clog2(TICK_DELAY + 1) : 1;
    localparam int PTR_W = $clog2(CMD_DEPTH);

    localparam logic [1:0]       C_OP_SHIFT = 2'd0;
    localparam logic [1:0]       C_OP_TRST  = 2'd1;
    localparam logic [1:0]       C_OP_IDLE  = 2'd2;
    localparam logic [1:0]       C_OP_EXIT  = 2'd3;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(TICK_DELAY);
    localparam logic [LEN_W-1:0] C_LEN_MAX  = LEN_W'(SHIFT_W);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOW  = 3'd1,
        S_HIGH = 3'd2,
        S_RESP = 3'd3,
        S_HALT = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO (pointers carry an extra wrap bit for full/empty)
    // ------------------------------------------------------------------
    logic [1:0]         op_mem  [CMD_DEPTH];
    logic [LEN_W-1:0]   len_mem [CMD_DEPTH];
    logic [SHIFT_W-1:0] tms_mem [CMD_DEPTH];
    logic [SHIFT_W-1:0] tdi_mem [CMD_DEPTH];

    logic [PTR_W:0] wr_ptr_q;
    logic [PTR_W:0] rd_ptr_q;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [1:0]         w_rd_op;
    logic [LEN_W-1:0]   w_rd_len;
    logic [LEN_W-1:0]   w_rd_len_clamped;
    logic [SHIFT_W-1:0] w_rd_tms;
    logic [SHIFT_W-1:0] w_rd_tdi;
    logic [31:0]        w_exit_val;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [LEN_W-1:0]   bit_q,    bit_d;
    logic [1:0]         op_q,     op_d;
    logic [LEN_W-1:0]   len_q,    len_d;
    logic [SHIFT_W-1:0] tmsv_q,   tmsv_d;
    logic [SHIFT_W-1:0] tdiv_q,   tdiv_d;
    logic [SHIFT_W-1:0] cap_q,    cap_d;
    logic               tck_q,    tck_d;
    logic               tms_q,    tms_d;
    logic               tdi_q,    tdi_d;
    logic               trstn_q,  trstn_d;
    logic [31:0]        exit_q,   exit_d;
    logic               sticky_q;

    logic w_capture;
    logic w_undriven;
    logic w_sample;

    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign cmd_ready = !w_full && !reset;
    assign w_push    = cmd_valid && cmd_ready;
    // One outstanding command at a time: popping only from IDLE also
    // guarantees no pop while a response is pending or after EXIT.
    assign w_pop     = enable && sticky_q && !w_empty &&
                       (state_q == S_IDLE) && (exit_q == 32'd0);

    assign w_rd_op  = op_mem [rd_ptr_q[PTR_W-1:0]];
    assign w_rd_len = len_mem[rd_ptr_q[PTR_W-1:0]];
    assign w_rd_tms = tms_mem[rd_ptr_q[PTR_W-1:0]];
    assign w_rd_tdi = tdi_mem[rd_ptr_q[PTR_W-1:0]];

    assign w_rd_len_clamped = (w_rd_len > C_LEN_MAX) ? C_LEN_MAX : w_rd_len;

    // The exit code is the TDI vector fitted into 32 bits.
    generate
        if (SHIFT_W >= 32) begin : g_exit_trunc
            assign w_exit_val = w_rd_tdi[31:0];
        end else begin : g_exit_zext
            assign w_exit_val = {{(32 - SHIFT_W){1'b0}}, w_rd_tdi};
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (w_push) begin
            op_mem [wr_ptr_q[PTR_W-1:0]] <= cmd_op;
            len_mem[wr_ptr_q[PTR_W-1:0]] <= cmd_len;
            tms_mem[wr_ptr_q[PTR_W-1:0]] <= cmd_tms;
            tdi_mem[wr_ptr_q[PTR_W-1:0]] <= cmd_tdi;
        end
    end

    // ------------------------------------------------------------------
    // TDO sampling
    // ------------------------------------------------------------------
    assign w_capture = (state_q == S_LOW) && (cnt_q == '0) && (op_q == C_OP_SHIFT);

`ifdef SIM_JTAG_RAND_TDO_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Taps 16,14,13,11 in right-shift Fibonacci form; output is bit 0.
    always_comb begin
        lfsr_d = lfsr_q;
        if (w_capture) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign w_undriven = lfsr_q[0];
`else
    assign w_undriven = 1'b0;
`endif

    assign w_sample = jtag_TDO_driven ? jtag_TDO_data : w_undriven;

    // Pin values {TRSTn, TMS, TDI} for bit idx of a command.
    function automatic logic [2:0] f_bit_pins(
        input logic [1:0]         op,
        input logic [SHIFT_W-1:0] tms,
        input logic [SHIFT_W-1:0] tdi,
        input logic [LEN_W-1:0]   idx
    );
        logic [SHIFT_W-1:0] sel;
        sel = SHIFT_W'(1) << idx;
        case (op)
            C_OP_SHIFT: f_bit_pins = {1'b1, (tms & sel) != '0, (tdi & sel) != '0};
            C_OP_TRST:  f_bit_pins = 3'b010;
            C_OP_IDLE:  f_bit_pins = 3'b100;
            default:    f_bit_pins = 3'b110;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        op_d    = op_q;
        len_d   = len_q;
        tmsv_d  = tmsv_q;
        tdiv_d  = tdiv_q;
        cap_d   = cap_q;
        tck_d   = tck_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        trstn_d = trstn_q;
        exit_d  = exit_q;

        case (state_q)
            S_IDLE: begin
                if (w_pop) begin
                    op_d   = w_rd_op;
                    len_d  = w_rd_len_clamped;
                    tmsv_d = w_rd_tms;
                    tdiv_d = w_rd_tdi;
                    cap_d  = '0;
                    if (w_rd_op == C_OP_EXIT) begin
                        exit_d  = (w_exit_val == 32'd0) ? 32'd1 : w_exit_val;
                        tms_d   = 1'b1;
                        tdi_d   = 1'b0;
                        trstn_d = 1'b1;
                        state_d = S_HALT;
                    end else if (w_rd_len_clamped == '0) begin
                        // Empty SHIFT still answers (with zeros); others are no-ops.
                        if (w_rd_op == C_OP_SHIFT) begin
                            state_d = S_RESP;
                        end
                    end else begin
                        bit_d   = '0;
                        cnt_d   = C_CNT_LOAD;
                        {trstn_d, tms_d, tdi_d} = f_bit_pins(w_rd_op, w_rd_tms, w_rd_tdi, '0);
                        state_d = S_LOW;
                    end
                end
            end

            S_LOW: begin
                if (cnt_q == '0) begin
                    tck_d = 1'b1;
                    if (op_q == C_OP_SHIFT) begin
                        cap_d = cap_q | (SHIFT_W'(w_sample) << bit_q);
                    end
                    cnt_d   = C_CNT_LOAD;
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_HIGH: begin
                if (cnt_q == '0) begin
                    tck_d = 1'b0;
                    if (bit_q == len_q - LEN_W'(1)) begin
                        if (op_q == C_OP_SHIFT) begin
                            state_d = S_RESP;
                        end else begin
                            trstn_d = 1'b1;
                            tms_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d   = bit_q + LEN_W'(1);
                        cnt_d   = C_CNT_LOAD;
                        {trstn_d, tms_d, tdi_d} =
                            f_bit_pins(op_q, tmsv_q, tdiv_q, bit_q + LEN_W'(1));
                        state_d = S_LOW;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            op_q     <= C_OP_SHIFT;
            len_q    <= '0;
            tmsv_q   <= '0;
            tdiv_q   <= '0;
            cap_q    <= '0;
            tck_q    <= 1'b0;
            tms_q    <= 1'b1;
            tdi_q    <= 1'b0;
            trstn_q  <= 1'b1;
            exit_q   <= '0;
            sticky_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            op_q     <= op_d;
            len_q    <= len_d;
            tmsv_q   <= tmsv_d;
            tdiv_q   <= tdiv_d;
            cap_q    <= cap_d;
            tck_q    <= tck_d;
            tms_q    <= tms_d;
            tdi_q    <= tdi_d;
            trstn_q  <= trstn_d;
            exit_q   <= exit_d;
            sticky_q <= sticky_q | init_done;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
            end
        end
    end

    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = cap_q;
    assign jtag_TCK   = tck_q;
    assign jtag_TMS   = tms_q;
    assign jtag_TDI   = tdi_q;
    assign jtag_TRSTn = trstn_q;
    assign exit       = exit_q;

endmodule
`default_nettype wire

// File: tb/tb_sim_jtag_seq_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sim_jtag_seq_driver
//  Purpose  : Self-checking bench for sim_jtag_seq_driver (TICK_DELAY=1,
//             so one TCK period is 4 clocks). A table of single commands is
//             replayed and checked against hand-computed results, followed
//             by hand-written sequences for init gating, FIFO full and
//             response back-pressure, EXIT/HALT, reset mid-shift and the
//             undriven-TDO sample value.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sim_jtag_seq_driver;

    localparam int TD   = 1;
    localparam int SW   = 32;
    localparam int HALF = TD + 1;

    localparam logic [1:0] OP_SHIFT = 2'd0;
    localparam logic [1:0] OP_TRST  = 2'd1;
    localparam logic [1:0] OP_IDLE  = 2'd2;
    localparam logic [1:0] OP_EXIT  = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        init_done;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_len;
    logic [31:0] cmd_tms;
    logic [31:0] cmd_tdi;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        tck, tms, tdi, trstn;
    logic        tdo_tie, tdo_val, tdo_drv;
    logic        tdo_data;
    logic [31:0] exit_code;

    // TDO either loops back TDI or is a constant.
    assign tdo_data = tdo_tie ? tdi : tdo_val;

    always #5 clk = ~clk;

    sim_jtag_seq_driver #(
        .TICK_DELAY (TD),
        .SHIFT_W    (SW),
        .CMD_DEPTH  (4),
        .LEN_W      (7)
    ) dut (
        .clock           (clk),
        .reset           (rst),
        .enable          (enable),
        .init_done       (init_done),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_len         (cmd_len),
        .cmd_tms         (cmd_tms),
        .cmd_tdi         (cmd_tdi),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .jtag_TCK        (tck),
        .jtag_TMS        (tms),
        .jtag_TDI        (tdi),
        .jtag_TRSTn      (trstn),
        .jtag_TDO_data   (tdo_data),
        .jtag_TDO_driven (tdo_drv),
        .exit            (exit_code)
    );

    // ------------------------------------------------------------------
    // Pin / handshake monitor (samples on the falling clock edge)
    // ------------------------------------------------------------------
    int          rises        = 0;
    int          tck_hi_cyc   = 0;
    int          trst_lo_cyc  = 0;
    int          tms_hi_rises = 0;
    int          resp_cnt     = 0;
    logic        tck_prev     = 1'b0;
    logic        tdi_hist[$];
    logic [31:0] resp_hist[$];

    always @(negedge clk) begin
        if (tck && !tck_prev) begin
            rises++;
            tdi_hist.push_back(tdi);
            if (tms) tms_hi_rises++;
        end
        if (tck) tck_hi_cyc++;
        if (!trstn) trst_lo_cyc++;
        if (resp_valid && resp_ready) begin
            resp_cnt++;
            resp_hist.push_back(resp_data);
        end
        tck_prev = tck;
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [6:0] len,
                        input logic [31:0] t, input logic [31:0] d);
        int w;
        w = 0;
        while (!cmd_ready && w < 300) begin
            tick(1);
            w++;
        end
        if (!cmd_ready) chk("push_ready_timeout", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_tms   = t;
        cmd_tdi   = d;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_resp(input int target, input int budget);
        int w;
        w = 0;
        while (resp_cnt < target && w < budget) begin
            tick(1);
            w++;
        end
        chk("resp_wait", 64'(resp_cnt), 64'(target));
    endtask

    function automatic logic [31:0] exp_undriven(input int n);
        logic [31:0] r;
        logic [15:0] s;
        logic        fb;
        r = '0;
        s = 16'hACE1;
        for (int i = 0; i < n; i++) begin
`ifdef SIM_JTAG_RAND_TDO_EN
            r[i] = s[0];
            fb   = s[0] ^ s[2] ^ s[3] ^ s[5];
            s    = {fb, s[15:1]};
`else
            r[i] = 1'b0;
            fb   = 1'b0;
            s    = s;
`endif
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Single-command vector table
    // tdo mode: 0 = TDO tied to TDI, 1 = driven 0, 2 = driven 1
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]  op;
        logic [6:0]  len;
        logic [31:0] tms;
        logic [31:0] tdi;
        int          mode;
        int          nresp;
        logic [31:0] resp;
        int          nrise;
        logic [31:0] tdi_log;
        int          tms_hi;
        int          trst_lo;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r0, n0, h0, t0, m0, w;
        logic [63:0] lg;

        vecs[0] = '{OP_SHIFT, 7'd4,  32'h0,        32'hA,        0, 1, 32'h0000000A, 4,  32'hA,        0, 0};
        vecs[1] = '{OP_SHIFT, 7'd8,  32'hA5,       32'hC3,       0, 1, 32'h000000C3, 8,  32'hC3,       4, 0};
        vecs[2] = '{OP_SHIFT, 7'd40, 32'hFFFF0000, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 32, 32'hDEADBEEF, 16, 0};
        vecs[3] = '{OP_SHIFT, 7'd0,  32'hFF,       32'hFF,       0, 1, 32'h00000000, 0,  32'h0,        0, 0};
        vecs[4] = '{OP_SHIFT, 7'd5,  32'h0,        32'hFFFFFFE0, 2, 1, 32'h0000001F, 5,  32'h0,        0, 0};
        vecs[5] = '{OP_SHIFT, 7'd3,  32'h7,        32'h7,        1, 1, 32'h00000000, 3,  32'h7,        3, 0};
        vecs[6] = '{OP_TRST,  7'd5,  32'h0,        32'hFF,       0, 0, 32'h0,        5,  32'h0,        5, 20};
        vecs[7] = '{OP_IDLE,  7'd3,  32'hFF,       32'hFF,       0, 0, 32'h0,        3,  32'h0,        0, 0};
        vecs[8] = '{OP_TRST,  7'd0,  32'hFF,       32'hFF,       0, 0, 32'h0,        0,  32'h0,        0, 0};
        vecs[9] = '{OP_SHIFT, 7'd32, 32'h0,        32'h80000001, 0, 1, 32'h80000001, 32, 32'h80000001, 0, 0};

        rst = 1'b1; enable = 1'b0; init_done = 1'b0; cmd_valid = 1'b0;
        cmd_op = OP_SHIFT; cmd_len = '0; cmd_tms = '0; cmd_tdi = '0;
        resp_ready = 1'b1; tdo_tie = 1'b1; tdo_val = 1'b0; tdo_drv = 1'b1;
        tick(3);

        // ---- reset values (reset still held) ----
        chk("rst_tck",        {63'd0, tck},        64'd0);
        chk("rst_tms",        {63'd0, tms},        64'd1);
        chk("rst_tdi",        {63'd0, tdi},        64'd0);
        chk("rst_trstn",      {63'd0, trstn},      64'd1);
        chk("rst_cmd_ready",  {63'd0, cmd_ready},  64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_data",  64'(resp_data),      64'd0);
        chk("rst_exit",       64'(exit_code),      64'd0);
        rst = 1'b0;
        tick(1);
        chk("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // ---- init gating, then a one-cycle init pulse releases both ----
        enable = 1'b1;
        r0 = rises;
        push(OP_SHIFT, 7'd4, 32'h0, 32'h5);
        push(OP_SHIFT, 7'd4, 32'h0, 32'h9);
        tick(20);
        chk("init_gate_no_tck", 64'(rises - r0), 64'd0);
        n0 = resp_cnt;
        init_done = 1'b1;
        tick(1);
        init_done = 1'b0;
        wait_resp(n0 + 2, 200);
        chk("init_both_rises", 64'(rises - r0), 64'd8);
        chk("init_resp0", 64'(resp_hist[n0]),     64'h5);
        chk("init_resp1", 64'(resp_hist[n0 + 1]), 64'h9);

        // ---- vector table ----
        for (int v = 0; v < NV; v++) begin
            tdo_tie = (vecs[v].mode == 0);
            tdo_val = (vecs[v].mode == 2);
            tdo_drv = 1'b1;
            r0 = rises; n0 = resp_cnt; h0 = tck_hi_cyc; t0 = trst_lo_cyc; m0 = tms_hi_rises;
            push(vecs[v].op, vecs[v].len, vecs[v].tms, vecs[v].tdi);
            tick(2 * HALF * SW + 20);
            chk($sformatf("v%0d_nresp", v), 64'(resp_cnt - n0), 64'(vecs[v].nresp));
            if (vecs[v].nresp == 1)
                chk($sformatf("v%0d_resp", v), 64'(resp_hist[n0]), 64'(vecs[v].resp));
            chk($sformatf("v%0d_rises", v), 64'(rises - r0), 64'(vecs[v].nrise));
            chk($sformatf("v%0d_tck_hi", v), 64'(tck_hi_cyc - h0), 64'(vecs[v].nrise * HALF));
            lg = '0;
            for (int i = 0; i < rises - r0 && i < 64; i++)
                lg = lg | (64'(tdi_hist[r0 + i]) << i);
            chk($sformatf("v%0d_tdi_seq", v), lg, 64'(vecs[v].tdi_log));
            chk($sformatf("v%0d_tms_hi", v), 64'(tms_hi_rises - m0), 64'(vecs[v].tms_hi));
            chk($sformatf("v%0d_trst_lo", v), 64'(trst_lo_cyc - t0), 64'(vecs[v].trst_lo));
            chk($sformatf("v%0d_trstn_end", v), {63'd0, trstn}, 64'd1);
            chk($sformatf("v%0d_tck_end", v), {63'd0, tck}, 64'd0);
        end

        // ---- FIFO full and response back-pressure ----
        tdo_tie = 1'b1; tdo_drv = 1'b1;
        resp_ready = 1'b0; enable = 1'b0;
        push(OP_SHIFT, 7'd2, 32'h0, 32'h1);
        push(OP_SHIFT, 7'd2, 32'h0, 32'h2);
        push(OP_SHIFT, 7'd2, 32'h0, 32'h3);
        push(OP_SHIFT, 7'd2, 32'h0, 32'h1);
        chk("full_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        n0 = resp_cnt;
        enable = 1'b1;
        w = 0;
        while (!resp_valid && w < 50) begin
            tick(1);
            w++;
        end
        chk("bp_valid", {63'd0, resp_valid}, 64'd1);
        chk("bp_data",  64'(resp_data), 64'h1);
        r0 = rises;
        tick(30);
        chk("bp_hold_valid", {63'd0, resp_valid}, 64'd1);
        chk("bp_hold_data",  64'(resp_data), 64'h1);
        chk("bp_no_tck",     64'(rises - r0), 64'd0);
        chk("bp_ready_after_pop", {63'd0, cmd_ready}, 64'd1);
        resp_ready = 1'b1;
        wait_resp(n0 + 4, 200);
        chk("bp_resp1", 64'(resp_hist[n0 + 1]), 64'h2);
        chk("bp_resp2", 64'(resp_hist[n0 + 2]), 64'h3);
        chk("bp_resp3", 64'(resp_hist[n0 + 3]), 64'h1);

        // ---- EXIT halts; queued SHIFT never runs ----
        r0 = rises; n0 = resp_cnt;
        push(OP_EXIT, 7'd0, 32'h0, 32'h2A);
        push(OP_SHIFT, 7'd4, 32'h0, 32'hF);
        tick(30);
        chk("exit_code",      64'(exit_code), 64'h2A);
        chk("exit_no_tck",    64'(rises - r0), 64'd0);
        chk("exit_no_resp",   64'(resp_cnt - n0), 64'd0);
        chk("halt_tms",       {63'd0, tms}, 64'd1);
        chk("halt_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        rst = 1'b1;
        tick(1);
        chk("exit_cleared", 64'(exit_code), 64'd0);
        rst = 1'b0;
        init_done = 1'b1;
        tick(1);
        init_done = 1'b0;
        push(OP_EXIT, 7'd0, 32'h0, 32'h0);
        tick(10);
        chk("exit_zero_forced", 64'(exit_code), 64'd1);

        // ---- reset during bit 3 of a SHIFT ----
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        init_done = 1'b1;
        tick(1);
        init_done = 1'b0;
        tdo_tie = 1'b1; tdo_drv = 1'b1;
        r0 = rises;
        push(OP_SHIFT, 7'd8, 32'h0, 32'hFF);
        push(OP_SHIFT, 7'd4, 32'h0, 32'h3);
        w = 0;
        while (rises - r0 < 4 && w < 200) begin
            tick(1);
            w++;
        end
        chk("mid_reach_bit3", 64'(rises - r0), 64'd4);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_tck",        {63'd0, tck},        64'd0);
        chk("mid_rst_tms",        {63'd0, tms},        64'd1);
        chk("mid_rst_tdi",        {63'd0, tdi},        64'd0);
        chk("mid_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("mid_rst_cmd_ready",  {63'd0, cmd_ready},  64'd0);
        rst = 1'b0;
        init_done = 1'b1;
        tick(1);
        init_done = 1'b0;
        r0 = rises; n0 = resp_cnt;
        tick(40);
        chk("flush_no_tck",  64'(rises - r0), 64'd0);
        chk("flush_no_resp", 64'(resp_cnt - n0), 64'd0);

        // ---- undriven TDO ----
        tdo_tie = 1'b0; tdo_val = 1'b1; tdo_drv = 1'b0;
        n0 = resp_cnt;
        push(OP_SHIFT, 7'd16, 32'h0, 32'h0);
        wait_resp(n0 + 1, 200);
        chk("undriven_resp", 64'(resp_hist[n0]), 64'(exp_undriven(16)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
